// File: rtl/ex_multicycle_scheduler_if.sv
// Handshake bundle between the EX stage, the multi-cycle units and the
// scheduler. The scheduler connects through the slave modport; the pipeline
// and unit side connects through the master modport.
interface ex_multicycle_scheduler_if;
    logic        ex_valid_i;
    logic        flush_i;
    logic        muldiv_start_i;
    logic        muldiv_sel_i;
    logic [1:0]  op_i;
    logic        fpu_start_i;
    logic [4:0]  fpu_func_i;
    logic [2:0]  fpu_rm_i;
    logic        mul_done_i;
    logic        div_done_i;
    logic        fpu_done_i;
    logic [31:0] mul_res_i;
    logic [31:0] div_res_i;
    logic [31:0] fpu_res_i;
    logic        mul_start_o;
    logic        div_start_o;
    logic        fpu_start_o;
    logic [1:0]  op_o;
    logic [4:0]  fpu_func_o;
    logic [2:0]  fpu_rm_o;
    logic        stall_o;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        busy_o;
    logic        timeout_o;

    modport master (
        output ex_valid_i, flush_i, muldiv_start_i, muldiv_sel_i, op_i,
               fpu_start_i, fpu_func_i, fpu_rm_i,
               mul_done_i, div_done_i, fpu_done_i,
               mul_res_i, div_res_i, fpu_res_i,
        input  mul_start_o, div_start_o, fpu_start_o, op_o, fpu_func_o,
               fpu_rm_o, stall_o, result_o, result_valid_o, busy_o, timeout_o
    );

    modport slave (
        input  ex_valid_i, flush_i, muldiv_start_i, muldiv_sel_i, op_i,
               fpu_start_i, fpu_func_i, fpu_rm_i,
               mul_done_i, div_done_i, fpu_done_i,
               mul_res_i, div_res_i, fpu_res_i,
        output mul_start_o, div_start_o, fpu_start_o, op_o, fpu_func_o,
               fpu_rm_o, stall_o, result_o, result_valid_o, busy_o, timeout_o
    );
endinterface

// File: rtl/ex_multicycle_scheduler.sv
// Multi-cycle EX scheduler: launches MUL/DIV/FPU units, stalls the pipeline
// while one is in flight, captures its result, and abandons it on flush or
// timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no unit in flight; accepts a new request
// MUL_WAIT | multiplier launched, waiting for mul_done_i
// DIV_WAIT | divider launched, waiting for div_done_i
// FPU_WAIT | FPU launched, waiting for fpu_done_i
// DONE     | result_o freshly captured; result_valid_o high for this cycle
// DRAIN    | instruction flushed; swallowing the abandoned unit's done
module ex_multicycle_scheduler #(
    parameter logic [7:0] TIMEOUT = 8'd64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    ex_multicycle_scheduler_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MUL_WAIT = 3'd1;
    localparam logic [2:0] S_DIV_WAIT = 3'd2;
    localparam logic [2:0] S_FPU_WAIT = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;

    localparam logic [1:0] U_MUL = 2'd0;
    localparam logic [1:0] U_DIV = 2'd1;
    localparam logic [1:0] U_FPU = 2'd2;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [1:0]  r_unit;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_inc;
    logic        r_drain_done;
    logic        r_mul_start;
    logic        r_div_start;
    logic        r_fpu_start;
    logic [1:0]  r_op;
    logic [4:0]  r_func;
    logic [2:0]  r_rm;
    logic [31:0] r_result;
    logic        w_req;
    logic        w_accept;
    logic        w_wait;
    logic        w_drain;
    logic        w_expired;
    logic        w_unit_done;
    logic [31:0] w_unit_res;
    logic        w_capture;

    assign w_req     = bus.ex_valid_i & ~bus.flush_i & (bus.muldiv_start_i | bus.fpu_start_i);
    assign w_accept  = (r_state == S_IDLE) & w_req;
    assign w_wait    = (r_state == S_MUL_WAIT) | (r_state == S_DIV_WAIT) | (r_state == S_FPU_WAIT);
    assign w_drain   = (r_state == S_DRAIN);
    assign w_cnt_inc = (r_cnt == 8'hFF) ? 8'hFF : r_cnt + 8'd1;
    // Compare with >= so a flush landing on the timeout cycle still expires in DRAIN.
    assign w_expired = (w_cnt_inc >= TIMEOUT);
    assign w_capture = w_wait & ~bus.flush_i & w_unit_done;

    // Select the done strobe and result of the unit currently owned.
    always_comb begin
        w_unit_done = 1'b0;
        w_unit_res  = 32'h0;
        case (r_unit)
            U_MUL:   begin w_unit_done = bus.mul_done_i; w_unit_res = bus.mul_res_i; end
            U_DIV:   begin w_unit_done = bus.div_done_i; w_unit_res = bus.div_res_i; end
            U_FPU:   begin w_unit_done = bus.fpu_done_i; w_unit_res = bus.fpu_res_i; end
            default: begin w_unit_done = 1'b0;           w_unit_res = 32'h0;         end
        endcase
    end

    // Next-state decode; in WAIT, flush beats done and done beats timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (bus.muldiv_start_i)
                        w_state_next = bus.muldiv_sel_i ? S_DIV_WAIT : S_MUL_WAIT;
                    else
                        w_state_next = S_FPU_WAIT;
                end
            end
            S_MUL_WAIT, S_DIV_WAIT, S_FPU_WAIT: begin
                if (bus.flush_i)
                    w_state_next = S_DRAIN;
                else if (w_unit_done)
                    w_state_next = S_DONE;
                else if (w_expired)
                    w_state_next = S_IDLE;
            end
            S_DONE:  w_state_next = S_IDLE;
            S_DRAIN: begin
                if (r_drain_done | w_unit_done | w_expired)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, owning unit, wait counter and the flush-with-done marker.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state      <= S_IDLE;
            r_unit       <= U_MUL;
            r_cnt        <= 8'h0;
            r_drain_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_drain_done <= w_wait & bus.flush_i & w_unit_done;
            if (w_accept) begin
                r_cnt  <= 8'h0;
                r_unit <= bus.muldiv_start_i ? (bus.muldiv_sel_i ? U_DIV : U_MUL) : U_FPU;
            end else if (w_wait | w_drain) begin
                r_cnt  <= w_cnt_inc;
            end
        end
    end

    // One-cycle launch pulses in the first WAIT cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_mul_start <= 1'b0;
            r_div_start <= 1'b0;
            r_fpu_start <= 1'b0;
        end else begin
            r_mul_start <= w_accept &  bus.muldiv_start_i & ~bus.muldiv_sel_i;
            r_div_start <= w_accept &  bus.muldiv_start_i &  bus.muldiv_sel_i;
            r_fpu_start <= w_accept & ~bus.muldiv_start_i;
        end
    end

    // Operation fields are frozen at acceptance so the unit sees stable inputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_op   <= 2'b0;
            r_func <= 5'b0;
            r_rm   <= 3'b0;
        end else if (w_accept) begin
            r_op   <= bus.op_i;
            r_func <= bus.fpu_func_i;
            r_rm   <= bus.fpu_rm_i;
        end
    end

    // Result register only updates on an unflushed completion.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)
            r_result <= 32'h0;
        else if (w_capture)
            r_result <= w_unit_res;
    end

    assign bus.mul_start_o    = r_mul_start;
    assign bus.div_start_o    = r_div_start;
    assign bus.fpu_start_o    = r_fpu_start;
    assign bus.op_o           = r_op;
    assign bus.fpu_func_o     = r_func;
    assign bus.fpu_rm_o       = r_rm;
    assign bus.result_o       = r_result;
    assign bus.result_valid_o = (r_state == S_DONE);
    assign bus.busy_o         = w_wait | w_drain;
    assign bus.stall_o        = w_wait | (((r_state == S_IDLE) | w_drain) & w_req);
    assign bus.timeout_o      = (w_wait & ~bus.flush_i & ~w_unit_done & w_expired)
                              | (w_drain & ~r_drain_done & ~w_unit_done & w_expired);
endmodule

// File: tb/tb_ex_multicycle_scheduler.sv
// Directed bench for ex_multicycle_scheduler. Inputs change on the falling
// edge; outputs are sampled 1 ns later. One cycle = negedge to negedge.
module tb_ex_multicycle_scheduler;
    logic clk_i;
    logic reset_i;
    int   n_checks = 0;
    int   n_errors = 0;
    int   stall_cycles;

    ex_multicycle_scheduler_if bus ();

    ex_multicycle_scheduler #(.TIMEOUT(8'd10)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        bus.ex_valid_i     = 1'b0;
        bus.flush_i        = 1'b0;
        bus.muldiv_start_i = 1'b0;
        bus.muldiv_sel_i   = 1'b0;
        bus.op_i           = 2'b0;
        bus.fpu_start_i    = 1'b0;
        bus.fpu_func_i     = 5'b0;
        bus.fpu_rm_i       = 3'b0;
        bus.mul_done_i     = 1'b0;
        bus.div_done_i     = 1'b0;
        bus.fpu_done_i     = 1'b0;
        bus.mul_res_i      = 32'h0;
        bus.div_res_i      = 32'h0;
        bus.fpu_res_i      = 32'h0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_starts"}, {29'h0, bus.mul_start_o, bus.div_start_o, bus.fpu_start_o}, 32'h0);
        chk({tag, "_stall"},  {31'h0, bus.stall_o}, 32'h0);
        chk({tag, "_busy"},   {31'h0, bus.busy_o}, 32'h0);
        chk({tag, "_rvalid"}, {31'h0, bus.result_valid_o}, 32'h0);
        chk({tag, "_tmo"},    {31'h0, bus.timeout_o}, 32'h0);
        chk({tag, "_result"}, bus.result_o, 32'h0);
        chk({tag, "_fields"}, {22'h0, bus.op_o, bus.fpu_func_o, bus.fpu_rm_o}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b0;
        clr_inputs();
        repeat (2) @(negedge clk_i);
        #1;
        chk_reset_vals("rst");
        @(negedge clk_i);
        reset_i = 1'b1;

        // MUL with done three cycles after the start pulse.
        stall_cycles = 0;
        @(negedge clk_i);
        bus.ex_valid_i = 1'b1; bus.muldiv_start_i = 1'b1; bus.muldiv_sel_i = 1'b0; bus.op_i = 2'b00;
        #1;
        chk("mul_c0_stall", {31'h0, bus.stall_o}, 32'h1);
        chk("mul_c0_nostart", {31'h0, bus.mul_start_o}, 32'h0);
        stall_cycles += int'(bus.stall_o);
        @(negedge clk_i);
        clr_inputs();
        #1;
        chk("mul_c1_start", {29'h0, bus.mul_start_o, bus.div_start_o, bus.fpu_start_o}, 32'h4);
        chk("mul_c1_busy", {31'h0, bus.busy_o}, 32'h1);
        stall_cycles += int'(bus.stall_o);
        @(negedge clk_i);
        #1;
        chk("mul_c2_start", {31'h0, bus.mul_start_o}, 32'h0);
        stall_cycles += int'(bus.stall_o);
        @(negedge clk_i);
        #1;
        stall_cycles += int'(bus.stall_o);
        @(negedge clk_i);
        bus.mul_done_i = 1'b1; bus.mul_res_i = 32'h0000_0C00;
        #1;
        chk("mul_c4_rvalid", {31'h0, bus.result_valid_o}, 32'h0);
        stall_cycles += int'(bus.stall_o);
        @(negedge clk_i);
        clr_inputs();
        #1;
        stall_cycles += int'(bus.stall_o);
        chk("mul_stall_cycles", stall_cycles, 32'd5);
        chk("mul_c5_rvalid", {31'h0, bus.result_valid_o}, 32'h1);
        chk("mul_c5_result", bus.result_o, 32'h0000_0C00);
        chk("mul_c5_busy", {31'h0, bus.busy_o}, 32'h0);
        @(negedge clk_i);
        #1;
        chk("mul_c6_rvalid", {31'h0, bus.result_valid_o}, 32'h0);
        chk("mul_c6_hold", bus.result_o, 32'h0000_0C00);

        // muldiv and fpu requested together: DIV wins, foreign done strobes ignored.
        @(negedge clk_i);
        bus.ex_valid_i = 1'b1; bus.muldiv_start_i = 1'b1; bus.muldiv_sel_i = 1'b1; bus.op_i = 2'b10;
        bus.fpu_start_i = 1'b1; bus.fpu_func_i = 5'h0A; bus.fpu_rm_i = 3'b011;
        #1;
        chk("both_c0_stall", {31'h0, bus.stall_o}, 32'h1);
        @(negedge clk_i);
        clr_inputs();
        #1;
        chk("both_c1_starts", {29'h0, bus.mul_start_o, bus.div_start_o, bus.fpu_start_o}, 32'h2);
        chk("both_c1_fields", {22'h0, bus.op_o, bus.fpu_func_o, bus.fpu_rm_o}, {22'h0, 2'b10, 5'h0A, 3'b011});
        @(negedge clk_i);
        bus.mul_done_i = 1'b1; bus.mul_res_i = 32'hFFFF_FFFF;
        bus.fpu_done_i = 1'b1; bus.fpu_res_i = 32'hEEEE_EEEE;
        bus.op_i = 2'b01;
        #1;
        chk("both_c2_starts", {29'h0, bus.mul_start_o, bus.div_start_o, bus.fpu_start_o}, 32'h0);
        @(negedge clk_i);
        clr_inputs();
        bus.div_done_i = 1'b1; bus.div_res_i = 32'h1234_5678;
        #1;
        chk("both_c3_busy", {31'h0, bus.busy_o}, 32'h1);
        chk("both_c3_rvalid", {31'h0, bus.result_valid_o}, 32'h0);
        chk("both_c3_result", bus.result_o, 32'h0000_0C00);
        chk("both_c3_op_held", {30'h0, bus.op_o}, 32'h2);
        @(negedge clk_i);
        clr_inputs();
        #1;
        chk("both_c4_rvalid", {31'h0, bus.result_valid_o}, 32'h1);
        chk("both_c4_result", bus.result_o, 32'h1234_5678);
        chk("both_c4_fpustart", {31'h0, bus.fpu_start_o}, 32'h0);

        // FPU flushed after two WAIT cycles; new request waits in DRAIN.
        @(negedge clk_i);
        bus.ex_valid_i = 1'b1; bus.fpu_start_i = 1'b1; bus.fpu_func_i = 5'h11; bus.fpu_rm_i = 3'b001;
        #1;
        chk("fpu_c0_stall", {31'h0, bus.stall_o}, 32'h1);
        @(negedge clk_i);
        clr_inputs();
        #1;
        chk("fpu_c1_starts", {29'h0, bus.mul_start_o, bus.div_start_o, bus.fpu_start_o}, 32'h1);
        @(negedge clk_i);
        #1;
        chk("fpu_c2_stall", {31'h0, bus.stall_o}, 32'h1);
        @(negedge clk_i);
        bus.flush_i = 1'b1;
        #1;
        chk("fpu_c3_stall", {31'h0, bus.stall_o}, 32'h1);
        @(negedge clk_i);
        clr_inputs();
        #1;
        chk("fpu_c4_stall", {31'h0, bus.stall_o}, 32'h0);
        chk("fpu_c4_busy", {31'h0, bus.busy_o}, 32'h1);
        chk("fpu_c4_rvalid", {31'h0, bus.result_valid_o}, 32'h0);
        @(negedge clk_i);
        bus.ex_valid_i = 1'b1; bus.muldiv_start_i = 1'b1; bus.muldiv_sel_i = 1'b0; bus.op_i = 2'b11;
        #1;
        chk("fpu_c5_stall_req", {31'h0, bus.stall_o}, 32'h1);
        chk("fpu_c5_busy", {31'h0, bus.busy_o}, 32'h1);
        @(negedge clk_i);
        bus.fpu_done_i = 1'b1; bus.fpu_res_i = 32'h3F80_0000;
        #1;
        chk("fpu_c6_busy", {31'h0, bus.busy_o}, 32'h1);
        chk("fpu_c6_mulstart", {31'h0, bus.mul_start_o}, 32'h0);
        @(negedge clk_i);
        bus.fpu_done_i = 1'b0; bus.fpu_res_i = 32'h0;
        #1;
        chk("fpu_c7_busy", {31'h0, bus.busy_o}, 32'h0);
        chk("fpu_c7_stall_req", {31'h0, bus.stall_o}, 32'h1);
        chk("fpu_c7_rvalid", {31'h0, bus.result_valid_o}, 32'h0);
        chk("fpu_c7_result", bus.result_o, 32'h1234_5678);

        // Waiting request accepted at c7; its done arrives with the start pulse.
        @(negedge clk_i);
        clr_inputs();
        bus.mul_done_i = 1'b1; bus.mul_res_i = 32'hAAAA_5555;
        #1;
        chk("one_c8_start", {31'h0, bus.mul_start_o}, 32'h1);
        chk("one_c8_rvalid", {31'h0, bus.result_valid_o}, 32'h0);
        @(negedge clk_i);
        clr_inputs();
        #1;
        chk("one_c9_rvalid", {31'h0, bus.result_valid_o}, 32'h1);
        chk("one_c9_result", bus.result_o, 32'hAAAA_5555);
        chk("one_c9_op", {30'h0, bus.op_o}, 32'h3);
        @(negedge clk_i);
        #1;
        chk("one_c10_rvalid", {31'h0, bus.result_valid_o}, 32'h0);

        // Flush and done in the same WAIT cycle: one DRAIN cycle, no capture.
        @(negedge clk_i);
        bus.ex_valid_i = 1'b1; bus.muldiv_start_i = 1'b1; bus.muldiv_sel_i = 1'b1; bus.op_i = 2'b01;
        @(negedge clk_i);
        clr_inputs();
        #1;
        chk("fd_c1_divstart", {31'h0, bus.div_start_o}, 32'h1);
        @(negedge clk_i);
        bus.flush_i = 1'b1; bus.div_done_i = 1'b1; bus.div_res_i = 32'hDEAD_BEEF;
        #1;
        chk("fd_c2_stall", {31'h0, bus.stall_o}, 32'h1);
        @(negedge clk_i);
        clr_inputs();
        #1;
        chk("fd_c3_busy", {31'h0, bus.busy_o}, 32'h1);
        chk("fd_c3_stall", {31'h0, bus.stall_o}, 32'h0);
        chk("fd_c3_rvalid", {31'h0, bus.result_valid_o}, 32'h0);
        @(negedge clk_i);
        #1;
        chk("fd_c4_busy", {31'h0, bus.busy_o}, 32'h0);
        chk("fd_c4_rvalid", {31'h0, bus.result_valid_o}, 32'h0);
        chk("fd_c4_result", bus.result_o, 32'hAAAA_5555);

        // DIV never completes: timeout on the 10th WAIT cycle.
        @(negedge clk_i);
        bus.ex_valid_i = 1'b1; bus.muldiv_start_i = 1'b1; bus.muldiv_sel_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
            clr_inputs();
            #1;
            chk($sformatf("tmo_w%0d_pulse", k), {31'h0, bus.timeout_o}, {31'h0, (k == 10)});
            chk($sformatf("tmo_w%0d_stall", k), {31'h0, bus.stall_o}, 32'h1);
        end
        @(negedge clk_i);
        #1;
        chk("tmo_after_pulse", {31'h0, bus.timeout_o}, 32'h0);
        chk("tmo_after_stall", {31'h0, bus.stall_o}, 32'h0);
        chk("tmo_after_busy", {31'h0, bus.busy_o}, 32'h0);
        chk("tmo_after_rvalid", {31'h0, bus.result_valid_o}, 32'h0);
        chk("tmo_after_result", bus.result_o, 32'hAAAA_5555);

        // Reset during MUL_WAIT, then a stale done after release.
        @(negedge clk_i);
        bus.ex_valid_i = 1'b1; bus.muldiv_start_i = 1'b1; bus.muldiv_sel_i = 1'b0;
        bus.op_i = 2'b01; bus.fpu_func_i = 5'h1F; bus.fpu_rm_i = 3'b111;
        @(negedge clk_i);
        clr_inputs();
        #1;
        chk("rmid_c1_busy", {31'h0, bus.busy_o}, 32'h1);
        @(negedge clk_i);
        reset_i = 1'b0;
        #1;
        chk_reset_vals("rmid");
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        bus.mul_done_i = 1'b1; bus.mul_res_i = 32'h5555_5555;
        #1;
        chk("rmid_done_stall", {31'h0, bus.stall_o}, 32'h0);
        @(negedge clk_i);
        clr_inputs();
        #1;
        chk_reset_vals("rmid_after");
        @(negedge clk_i);
        #1;
        chk("rmid_final_rvalid", {31'h0, bus.result_valid_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
